// File: rtl/ps2_color_cmd_if.sv
// rtl/ps2_color_cmd_if.sv - scan byte in, colour/selection/status out for the keyboard colour decoder
interface ps2_color_cmd_if;
  logic [7:0] iCode;
  logic       iCodeReady;
  logic [9:0] oRed;
  logic [9:0] oGreen;
  logic [9:0] oBlue;
  logic [1:0] oSel;
  logic [7:0] oLastMake;
  logic       oCmdValid;

  modport master (
    output iCode, iCodeReady,
    input  oRed, oGreen, oBlue, oSel, oLastMake, oCmdValid
  );

  modport slave (
    input  iCode, iCodeReady,
    output oRed, oGreen, oBlue, oSel, oLastMake, oCmdValid
  );
endinterface

// File: rtl/ps2_color_cmd.sv
// rtl/ps2_color_cmd.sv - PS/2 set-2 scan byte decoder driving the VGA R/G/B channel values
module ps2_color_cmd #(
  parameter logic [9:0] DIGIT_STEP = 10'd100,
  parameter logic [9:0] INC_STEP   = 10'd16,
  parameter logic [1:0] SEL_RST    = 2'd0
) (
  input logic              CLK_50,
  input logic              nRst,
  ps2_color_cmd_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t      state;
  logic        s1, s2, s3;
  logic        strobe;
  logic [9:0]  red, green, blue;
  logic [1:0]  sel;
  logic [7:0]  last_make;
  logic        cmd_valid;

  logic [9:0]  cur;
  logic        digit_hit;
  logic [3:0]  digit;
  logic [13:0] prod;
  logic [9:0]  dig_val;
  logic [10:0] sum;
  logic [9:0]  inc_val;
  logic [9:0]  dec_val;
  logic        wr;
  logic [9:0]  wr_val;
  logic [1:0]  new_sel;
  logic        clear_all;
  logic        is_cmd;

  assign strobe = s2 & ~s3;

  always_comb begin
    case (sel)
      2'd1:    cur = green;
      2'd2:    cur = blue;
      default: cur = red;
    endcase

    digit_hit = 1'b1;
    digit     = 4'd0;
    case (bus.iCode)
      8'h45:   digit = 4'd0;
      8'h16:   digit = 4'd1;
      8'h1E:   digit = 4'd2;
      8'h26:   digit = 4'd3;
      8'h25:   digit = 4'd4;
      8'h2E:   digit = 4'd5;
      8'h36:   digit = 4'd6;
      8'h3D:   digit = 4'd7;
      8'h3E:   digit = 4'd8;
      8'h46:   digit = 4'd9;
      default: digit_hit = 1'b0;
    endcase

    // Products and sums are widened so saturation can be detected before truncation
    prod    = 14'(DIGIT_STEP) * 14'(digit);
    dig_val = (prod > 14'd1023) ? 10'd1023 : prod[9:0];
    sum     = {1'b0, cur} + {1'b0, INC_STEP};
    inc_val = sum[10] ? 10'd1023 : sum[9:0];
    dec_val = (cur < INC_STEP) ? 10'd0 : cur - INC_STEP;

    wr        = 1'b0;
    wr_val    = cur;
    new_sel   = sel;
    clear_all = 1'b0;
    is_cmd    = 1'b1;
    case (bus.iCode)
      8'h2D: new_sel = 2'd0;
      8'h34: new_sel = 2'd1;
      8'h32: new_sel = 2'd2;
      8'h55: begin wr = 1'b1; wr_val = inc_val; end
      8'h4E: begin wr = 1'b1; wr_val = dec_val; end
      8'h66: begin wr = 1'b1; wr_val = 10'd0;   end
      8'h76: begin clear_all = 1'b1; new_sel = SEL_RST; end
      default: begin
        if (digit_hit) begin
          wr     = 1'b1;
          wr_val = dig_val;
        end else begin
          is_cmd = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (!nRst) begin
      state     <= IDLE;
      s1        <= 1'b1;
      s2        <= 1'b1;
      s3        <= 1'b1;
      red       <= 10'd0;
      green     <= 10'd0;
      blue      <= 10'd0;
      sel       <= SEL_RST;
      last_make <= 8'h00;
      cmd_valid <= 1'b0;
    end else begin
      s1        <= bus.iCodeReady;
      s2        <= s1;
      s3        <= s2;
      cmd_valid <= 1'b0;
      if (strobe) begin
        case (state)
          IDLE: begin
            if (bus.iCode == 8'hF0) begin
              state <= BRK;
            end else if (bus.iCode == 8'hE0) begin
              state <= EXT;
            end else begin
              last_make <= bus.iCode;
              cmd_valid <= is_cmd;
              sel       <= new_sel;
              if (clear_all) begin
                red   <= 10'd0;
                green <= 10'd0;
                blue  <= 10'd0;
              end else if (wr) begin
                case (sel)
                  2'd1:    green <= wr_val;
                  2'd2:    blue  <= wr_val;
                  default: red   <= wr_val;
                endcase
              end
            end
          end
          EXT:     state <= (bus.iCode == 8'hF0) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.oRed      = red;
  assign bus.oGreen    = green;
  assign bus.oBlue     = blue;
  assign bus.oSel      = sel;
  assign bus.oLastMake = last_make;
  assign bus.oCmdValid = cmd_valid;
endmodule
